// File: rtl/fifo_route_pkg.sv
// rtl/fifo_route_pkg.sv - shared constants and helpers for the FIFO routing stage
//
// Purpose : FSM state encodings, port/field geometry and a one-hot helper
//           shared by the round-robin arbiter and its picker.
// Ports   : none (package).

package fifo_route_pkg;

  localparam int N_PORTS  = 4;
  localparam int DEST_W   = 2;
  localparam int WORD_W   = 10;
  // Destination field sits in the top DEST_W bits of each routed word ([9:8]).
  localparam int DEST_LSB = WORD_W - DEST_W;

  typedef logic [1:0] state_t;

  localparam state_t ST_RESET  = 2'd0;
  localparam state_t ST_INIT   = 2'd1;
  localparam state_t ST_IDLE   = 2'd2;
  localparam state_t ST_ACTIVE = 2'd3;

  function automatic logic [N_PORTS-1:0] onehot4(input logic [DEST_W-1:0] idx);
    return N_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Purpose : Finds the first eligible requester scanning ptr, ptr+1, ... mod 4.
// Ports   : i_elig[3:0]    eligible requesters (bit i = requester i)
//           i_ptr[1:0]     index with highest priority this cycle
//           o_gnt_valid    at least one requester is eligible
//           o_gnt_idx[1:0] winning requester index (0 when none)

module rr_pick4
  import fifo_route_pkg::*;
(
  input  logic [N_PORTS-1:0] i_elig,
  input  logic [1:0]         i_ptr,
  output logic               o_gnt_valid,
  output logic [1:0]         o_gnt_idx
);

  logic [1:0] w_cand;

  // Walk the ring from the far end towards ptr so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = 2'd0;
    w_cand      = i_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_elig[w_cand]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin control stage for the 4x4 routing mux
//
// Purpose : Each cycle grants at most one input FIFO whose head word can be
//           accepted by its destination output FIFO, driving the mux select,
//           the input pop strobe and the output push strobe with zero latency.
// Ports   : i_clk                 rising-edge clock
//           i_reset               synchronous active-high reset
//           i_in_empty[3:0]       empty flags of input fifo0..3
//           i_head_dest[7:0]      head dest of input i at [2i+1:2i]
//           i_out_almost_full[3:0] almost-full flags of output fifo4..7
//           i_pause               hold off new grants
//           o_demux0[1:0]         mux select (grant index, else last grant)
//           o_pop[3:0]            one-hot pop to input fifos
//           o_push[3:0]           one-hot push to output fifos
//           o_idle                registered, 1 while FSM is IDLE
//           o_grant_cnt[4*CNT_W-1:0] saturating per-input grant counters

module fifo_rr_arbiter
  import fifo_route_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_PORTS-1:0]       i_in_empty,
  input  logic [N_PORTS*DEST_W-1:0] i_head_dest,
  input  logic [N_PORTS-1:0]       i_out_almost_full,
  input  logic                     i_pause,
  output logic [1:0]               o_demux0,
  output logic [N_PORTS-1:0]       o_pop,
  output logic [N_PORTS-1:0]       o_push,
  output logic                     o_idle,
  output logic [N_PORTS*CNT_W-1:0] o_grant_cnt
);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [1:0]               r_ptr;
  logic [1:0]               r_last_grant;
  logic                     r_idle;
  logic [N_PORTS*CNT_W-1:0] r_grant_cnt;

  logic [N_PORTS-1:0] w_elig;
  logic               w_gnt_valid;
  logic [1:0]         w_gnt_idx;
  logic               w_grant;
  logic [DEST_W-1:0]  w_gnt_dest;
  logic [CNT_W-1:0]   w_cnt_cur;

  // An input is eligible only when it has data and its head's target can take it,
  // so a blocked input never stalls the others.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_elig[i] = !i_in_empty[i] && !i_out_almost_full[i_head_dest[DEST_W*i +: DEST_W]];
    end
  end

  rr_pick4 u_pick (
    .i_elig      (w_elig),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  // Reset is folded in so pop/push drop in the very cycle reset rises.
  assign w_grant    = (r_state == ST_ACTIVE) && !i_pause && w_gnt_valid && !i_reset;
  assign w_gnt_dest = i_head_dest[{w_gnt_idx, 1'b0} +: DEST_W];
  assign w_cnt_cur  = r_grant_cnt[CNT_W*int'(w_gnt_idx) +: CNT_W];

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET:  w_next_state = ST_INIT;
      ST_INIT:   w_next_state = ST_IDLE;
      ST_IDLE:   if (i_in_empty != '1) w_next_state = ST_ACTIVE;
      ST_ACTIVE: if (i_in_empty == '1) w_next_state = ST_IDLE;
      default:   w_next_state = ST_RESET;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_pop    = '0;
    o_push   = '0;
    o_demux0 = r_last_grant;
    if (w_grant) begin
      o_pop    = onehot4(w_gnt_idx);
      o_push   = onehot4(w_gnt_dest);
      o_demux0 = w_gnt_idx;
    end
  end

  // Pointer, last grant and counters; INIT clears them just like reset.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == ST_INIT)) begin
      r_ptr        <= 2'd0;
      r_last_grant <= 2'd0;
      r_grant_cnt  <= '0;
    end else if (w_grant) begin
      r_ptr        <= w_gnt_idx + 2'd1;
      r_last_grant <= w_gnt_idx;
      if (w_cnt_cur != '1) begin
        r_grant_cnt[CNT_W*int'(w_gnt_idx) +: CNT_W] <= w_cnt_cur + CNT_W'(1);
      end
    end
  end

  // idle is registered from the next state so it lines up with r_state == ST_IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idle <= 1'b0;
    end else begin
      r_idle <= (w_next_state == ST_IDLE);
    end
  end

  assign o_idle      = r_idle;
  assign o_grant_cnt = r_grant_cnt;

endmodule
